uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared types and default sizes for the UART TX scheduler.
// Holds the scheduler FSM state enum and default WIDTH/NUM_REQ/BUSY_TIMEOUT.
package uart_tx_sched_pkg;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_BUSY_TIMEOUT = 4;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at last_grant+1.
// Ports: req (requests), last_grant (previous winner), grant (one-hot), grant_idx.
module rr_arbiter
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx
);

   // Scan from the farthest offset down to the nearest so the requester
   // closest after last_grant is the final (winning) assignment.
   always_comb begin
      logic [IW-1:0] k;
      grant     = '0;
      grant_idx = '0;
      k         = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         k = IW'((int'(last_grant) + i) % NUM_REQ);
         if (req[k]) grant_idx = k;
      end
      if (|req) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among NUM_REQ requesters.
// Ports: req_* (requester side), Data_valid/P_data/Par_* /Busy (UART side),
// grant_id, tx_done and timeout_err (status). rst is async active-low.
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]         req_par_en,
   input  logic [NUM_REQ-1:0]         req_par_type,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       Data_valid,
   output logic [WIDTH-1:0]           P_data,
   output logic                       Par_en,
   output logic                       Par_type,
   input  logic                       Busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       tx_done,
   output logic                       timeout_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(BUSY_TIMEOUT);

   sched_state_t state, state_nx;

   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic [CW-1:0]      to_cnt;
   logic               accept;
   logic [WIDTH-1:0]   sel_data;
   logic               sel_pe;
   logic               sel_pt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   always_comb begin
      sel_data = '0;
      sel_pe   = 1'b0;
      sel_pt   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_data = req_data[i*WIDTH +: WIDTH];
            sel_pe   = req_par_en[i];
            sel_pt   = req_par_type[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // rst gates the accept path so req_ready is zero while reset is held.
   always_comb begin
      state_nx    = state;
      req_ready   = '0;
      Data_valid  = 1'b0;
      tx_done     = 1'b0;
      timeout_err = 1'b0;
      accept      = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst && !Busy && |req_valid) begin
               accept    = 1'b1;
               req_ready = arb_grant;
               state_nx  = LAUNCH;
            end
         end
         LAUNCH: begin
            Data_valid = 1'b1;
            state_nx   = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (Busy) begin
               state_nx = WAIT_DONE;
            end else if (to_cnt == TO_MAX) begin
               timeout_err = 1'b1;
               state_nx    = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!Busy) begin
               tx_done  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= IW'(NUM_REQ - 1);
         grant_id   <= '0;
         P_data     <= '0;
         Par_en     <= 1'b0;
         Par_type   <= 1'b0;
         to_cnt     <= '0;
      end else begin
         if (accept) begin
            last_grant <= arb_idx;
            grant_id   <= arb_idx;
            P_data     <= sel_data;
            Par_en     <= sel_pe;
            Par_type   <= sel_pt;
         end
         // Cleared while launching so WAIT_BUSY always starts from zero.
         if (state == LAUNCH) begin
            to_cnt <= '0;
         end else if (state == WAIT_BUSY && !Busy && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + CW'(1);
         end
      end
   end

endmodule
